// File: rtl/ad9958_spi_responder_if.sv
// Serial link from the AD9958 host side: SPI lines plus the asynchronous commit and reset strobes.
interface ad9958_spi_responder_if;
  logic       sclk;
  logic       cs_n;
  logic [3:0] sdio;
  logic       io_update;
  logic       master_reset;

  modport master (output sclk, cs_n, sdio, io_update, master_reset);
  modport slave  (input  sclk, cs_n, sdio, io_update, master_reset);
endinterface

// File: rtl/ad9958_spi_responder.sv
// AD9958 serial-port slave: decodes instruction/data frames into per-channel shadow registers
// and commits them to the active outputs on io_update.
module ad9958_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CSR_DEFAULT = 8'hF0,
  parameter logic [23:0] CFR_DEFAULT = 24'h000302
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  ad9958_spi_responder_if.slave spi_io,
  output logic [7:0]            csr_o,
  output logic [23:0]           fr1_o,
  output logic [23:0]           cfr_ch0_o,
  output logic [23:0]           cfr_ch1_o,
  output logic [31:0]           ftw_ch0_o,
  output logic [31:0]           ftw_ch1_o,
  output logic [12:0]           asf_ch0_o,
  output logic [12:0]           asf_ch1_o,
  output logic                  wr_strobe_o,
  output logic [4:0]            wr_addr_o,
  output logic                  frame_err_o
);

  typedef enum logic [1:0] {StIdle, StInst, StData, StIgnore} state_e;

  localparam logic [7:0] SyncRst = 8'b0000_0010;  // cs_n idles high

  // sdio shares the sclk synchronizer depth so data and clock stay aligned
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_out;
  logic       sclk_s, cs_n_s, iou_s, mr_s;
  logic [3:0] sdio_s;
  logic       sclk_prev_q, cs_n_prev_q, iou_prev_q;
  logic       sclk_rise, cs_rise, cs_fall, iou_rise;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SyncRst;
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
      iou_prev_q  <= 1'b0;
    end else begin
      sync_q[0] <= {spi_io.master_reset, spi_io.io_update, spi_io.sdio, spi_io.cs_n, spi_io.sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
      iou_prev_q  <= iou_s;
    end
  end

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign sclk_s    = sync_out[0];
  assign cs_n_s    = sync_out[1];
  assign sdio_s    = sync_out[5:2];
  assign iou_s     = sync_out[6];
  assign mr_s      = sync_out[7];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;
  assign iou_rise  = iou_s & ~iou_prev_q;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d, len_q, len_d;
  logic [4:0]        addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        csr_q, csr_d;
  logic [23:0]       fr1_sh_q, fr1_sh_d, fr1_q, fr1_d;
  logic [1:0][23:0]  cfr_sh_q, cfr_sh_d, cfr_q, cfr_d;
  logic [1:0][31:0]  ftw_sh_q, ftw_sh_d, ftw_q, ftw_d;
  logic [1:0][12:0]  asf_sh_q, asf_sh_d, asf_q, asf_d;
  logic              wr_strobe_q, wr_strobe_d, frame_err_q, frame_err_d;

  logic [2:0]  bpe;
  logic [5:0]  cnt_nx;
  logic [31:0] shift_nx, rev_nx, field;

  // Field as it would stand if the current sclk edge completed the word
  always_comb begin
    unique case (csr_q[2:1])
      2'b10: begin
        bpe      = 3'd2;
        shift_nx = {shift_q[29:0], sdio_s[1:0]};
      end
      2'b11: begin
        bpe      = 3'd4;
        shift_nx = {shift_q[27:0], sdio_s};
      end
      default: begin
        bpe      = 3'd1;
        shift_nx = {shift_q[30:0], sdio_s[0]};
      end
    endcase
    cnt_nx = cnt_q + 6'(bpe);
    for (int i = 0; i < 32; i++) rev_nx[i] = shift_nx[31-i];
    field = csr_q[0] ? (rev_nx >> (6'd32 - cnt_nx)) : shift_nx;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    csr_d       = csr_q;
    fr1_sh_d    = fr1_sh_q;
    cfr_sh_d    = cfr_sh_q;
    ftw_sh_d    = ftw_sh_q;
    asf_sh_d    = asf_sh_q;
    fr1_d       = fr1_q;
    cfr_d       = cfr_q;
    ftw_d       = ftw_q;
    asf_d       = asf_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = frame_err_q;

    if (cs_rise) begin
      state_d = StIdle;
      cnt_d   = '0;
      shift_d = '0;
      if (cnt_q != '0) frame_err_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d = StInst;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        StInst: begin
          if (sclk_rise) begin
            shift_d = shift_nx;
            cnt_d   = cnt_nx;
            if (cnt_nx == 6'd8) begin
              cnt_d   = '0;
              shift_d = '0;
              addr_d  = field[4:0];
              state_d = StData;
              if (field[7]) begin
                state_d     = StIgnore;
                frame_err_d = 1'b1;
              end else begin
                case (field[6:0])
                  7'h00:   len_d = 6'd8;
                  7'h01,
                  7'h03,
                  7'h06:   len_d = 6'd24;
                  7'h04:   len_d = 6'd32;
                  default: begin
                    state_d     = StIgnore;
                    frame_err_d = 1'b1;
                  end
                endcase
              end
            end
          end
        end
        StData: begin
          if (sclk_rise) begin
            shift_d = shift_nx;
            cnt_d   = cnt_nx;
            if (cnt_nx == len_q) begin
              cnt_d       = '0;
              shift_d     = '0;
              state_d     = StInst;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              if (addr_q == 5'h00) csr_d = field[7:0];
              if (addr_q == 5'h01) fr1_sh_d = field[23:0];
              for (int ch = 0; ch < 2; ch++) begin
                if (csr_q[6+ch]) begin
                  if (addr_q == 5'h03) cfr_sh_d[ch] = field[23:0];
                  if (addr_q == 5'h04) ftw_sh_d[ch] = field;
                  if (addr_q == 5'h06) asf_sh_d[ch] = field[12:0];
                end
              end
            end
          end
        end
        default: ;  // StIgnore: wait for cs_n to rise
      endcase
    end

    // Commit sees this cycle's write so a coincident completion is included
    if (iou_rise) begin
      fr1_d = fr1_sh_d;
      cfr_d = cfr_sh_d;
      ftw_d = ftw_sh_d;
      asf_d = asf_sh_d;
    end

    if (mr_s) begin
      state_d     = StIdle;
      cnt_d       = '0;
      len_d       = '0;
      addr_d      = '0;
      shift_d     = '0;
      csr_d       = CSR_DEFAULT;
      fr1_sh_d    = '0;
      cfr_sh_d    = {2{CFR_DEFAULT}};
      ftw_sh_d    = '0;
      asf_sh_d    = '0;
      fr1_d       = '0;
      cfr_d       = {2{CFR_DEFAULT}};
      ftw_d       = '0;
      asf_d       = '0;
      wr_strobe_d = 1'b0;
      wr_addr_d   = '0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      csr_q       <= CSR_DEFAULT;
      fr1_sh_q    <= '0;
      cfr_sh_q    <= {2{CFR_DEFAULT}};
      ftw_sh_q    <= '0;
      asf_sh_q    <= '0;
      fr1_q       <= '0;
      cfr_q       <= {2{CFR_DEFAULT}};
      ftw_q       <= '0;
      asf_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      csr_q       <= csr_d;
      fr1_sh_q    <= fr1_sh_d;
      cfr_sh_q    <= cfr_sh_d;
      ftw_sh_q    <= ftw_sh_d;
      asf_sh_q    <= asf_sh_d;
      fr1_q       <= fr1_d;
      cfr_q       <= cfr_d;
      ftw_q       <= ftw_d;
      asf_q       <= asf_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign csr_o       = csr_q;
  assign fr1_o       = fr1_q;
  assign cfr_ch0_o   = cfr_q[0];
  assign cfr_ch1_o   = cfr_q[1];
  assign ftw_ch0_o   = ftw_q[0];
  assign ftw_ch1_o   = ftw_q[1];
  assign asf_ch0_o   = asf_q[0];
  assign asf_ch1_o   = asf_q[1];
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_ad9958_spi_responder.sv
// Bench for ad9958_spi_responder: drives serial frames and checks outputs against a
// register-level model of the device.
module tb_ad9958_spi_responder;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ad9958_spi_responder_if spi_if ();

  logic [7:0]  csr;
  logic [23:0] fr1, cfr_ch0, cfr_ch1;
  logic [31:0] ftw_ch0, ftw_ch1;
  logic [12:0] asf_ch0, asf_ch1;
  logic        wr_strobe, frame_err;
  logic [4:0]  wr_addr;

  ad9958_spi_responder dut (
    .clock_i     (clk_i),
    .reset_ni    (rst_ni),
    .spi_io      (spi_if),
    .csr_o       (csr),
    .fr1_o       (fr1),
    .cfr_ch0_o   (cfr_ch0),
    .cfr_ch1_o   (cfr_ch1),
    .ftw_ch0_o   (ftw_ch0),
    .ftw_ch1_o   (ftw_ch1),
    .asf_ch0_o   (asf_ch0),
    .asf_ch1_o   (asf_ch1),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .frame_err_o (frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Register-level model: shadow (_s) and active (_a) copies
  logic [7:0]  m_csr;
  logic [23:0] m_fr1_s, m_fr1_a;
  logic [23:0] m_cfr_s [2];
  logic [23:0] m_cfr_a [2];
  logic [31:0] m_ftw_s [2];
  logic [31:0] m_ftw_a [2];
  logic [12:0] m_asf_s [2];
  logic [12:0] m_asf_a [2];
  logic        m_err;
  logic [4:0]  m_addr;
  int          m_wr_cnt = 0;
  int          strobe_cnt = 0;
  logic        strobe_prev = 1'b0;
  logic        chk_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_csr   = 8'hF0;
    m_fr1_s = '0;
    m_fr1_a = '0;
    for (int c = 0; c < 2; c++) begin
      m_cfr_s[c] = 24'h000302;
      m_cfr_a[c] = 24'h000302;
      m_ftw_s[c] = '0;
      m_ftw_a[c] = '0;
      m_asf_s[c] = '0;
      m_asf_a[c] = '0;
    end
    m_err  = 1'b0;
    m_addr = '0;
  endfunction

  function automatic void model_write(input logic [6:0] a, input logic [31:0] v);
    m_wr_cnt++;
    m_addr = a[4:0];
    for (int c = 0; c < 2; c++) begin
      if (m_csr[6+c]) begin
        if (a == 7'h03) m_cfr_s[c] = v[23:0];
        if (a == 7'h04) m_ftw_s[c] = v;
        if (a == 7'h06) m_asf_s[c] = v[12:0];
      end
    end
    if (a == 7'h01) m_fr1_s = v[23:0];
    if (a == 7'h00) m_csr = v[7:0];
  endfunction

  function automatic void model_commit();
    m_fr1_a = m_fr1_s;
    for (int c = 0; c < 2; c++) begin
      m_cfr_a[c] = m_cfr_s[c];
      m_ftw_a[c] = m_ftw_s[c];
      m_asf_a[c] = m_asf_s[c];
    end
  endfunction

  function automatic int bits_per_edge();
    case (m_csr[2:1])
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 1;
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("csr", 32'(csr), 32'(m_csr));
      chk("fr1", 32'(fr1), 32'(m_fr1_a));
      chk("cfr_ch0", 32'(cfr_ch0), 32'(m_cfr_a[0]));
      chk("cfr_ch1", 32'(cfr_ch1), 32'(m_cfr_a[1]));
      chk("ftw_ch0", ftw_ch0, m_ftw_a[0]);
      chk("ftw_ch1", ftw_ch1, m_ftw_a[1]);
      chk("asf_ch0", 32'(asf_ch0), 32'(m_asf_a[0]));
      chk("asf_ch1", 32'(asf_ch1), 32'(m_asf_a[1]));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("wr_count", strobe_cnt, m_wr_cnt);
    end
    if (wr_strobe) begin
      strobe_cnt++;
      chk("wr_strobe_width", 32'(strobe_prev), 32'd0);
    end
    strobe_prev = wr_strobe;
  end

  task automatic half();
    repeat (4) @(posedge clk_i);
    #2;
  endtask

  task automatic edge_out(input logic [3:0] d);
    spi_if.sdio = d;
    half();
    spi_if.sclk = 1'b1;
    half();
    spi_if.sclk = 1'b0;
  endtask

  // Sends the low n bits of val in the model's current width and bit order
  task automatic send_bits(input logic [31:0] val, input int n);
    logic [31:0] c;
    logic [3:0]  d;
    int          w;
    w = bits_per_edge();
    c = val;
    if (m_csr[0]) begin
      c = '0;
      for (int i = 0; i < n; i++) c[n-1-i] = val[i];
    end
    for (int b = n; b > 0; b -= w) begin
      d = 4'($urandom());
      if (w == 1) d[0] = c[b-1];
      else if (w == 2) d[1:0] = {c[b-1], c[b-2]};
      else d = {c[b-1], c[b-2], c[b-3], c[b-4]};
      edge_out(d);
    end
  endtask

  task automatic write_reg(input logic [6:0] a, input logic [31:0] v);
    int len;
    case (a)
      7'h00:   len = 8;
      7'h04:   len = 32;
      default: len = 24;
    endcase
    send_bits({25'b0, a}, 8);
    send_bits(v, len);
    model_write(a, v);
  endtask

  task automatic cs_low();
    spi_if.cs_n = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    spi_if.cs_n = 1'b1;
    half();
  endtask

  task automatic io_update_pulse();
    spi_if.io_update = 1'b1;
    half();
    spi_if.io_update = 1'b0;
    half();
    model_commit();
  endtask

  task automatic master_reset_pulse();
    spi_if.master_reset = 1'b1;
    repeat (6) @(posedge clk_i);
    #2;
    spi_if.master_reset = 1'b0;
    half();
    model_reset();
  endtask

  task automatic settle();
    repeat (10) @(posedge clk_i);
    #2;
    chk_en = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    chk_en = 1'b0;
  endtask

  task automatic rand_write();
    logic [6:0] a;
    case ($urandom_range(0, 4))
      0:       a = 7'h00;
      1:       a = 7'h01;
      2:       a = 7'h03;
      3:       a = 7'h04;
      default: a = 7'h06;
    endcase
    write_reg(a, $urandom());
  endtask

  task automatic bad_frame();
    logic [6:0] a;
    int kind;
    kind = $urandom_range(0, 2);
    cs_low();
    if (kind == 0) begin
      send_bits({24'b0, 1'b1, 7'($urandom())}, 8);
      send_bits($urandom(), 8);
    end else if (kind == 1) begin
      do a = 7'($urandom()); while (a == 7'h00 || a == 7'h01 || a == 7'h03 ||
                                    a == 7'h04 || a == 7'h06);
      send_bits({25'b0, a}, 8);
      send_bits($urandom(), 8);
    end else begin
      send_bits(32'h04, 8);
      send_bits($urandom(), 12);
    end
    cs_high();
    m_err = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    spi_if.sclk         = 1'b0;
    spi_if.cs_n         = 1'b1;
    spi_if.sdio         = 4'h0;
    spi_if.io_update    = 1'b0;
    spi_if.master_reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #2;
    chk("reset_csr", 32'(csr), 32'h0000_00F0);
    chk("reset_cfr_ch1", 32'(cfr_ch1), 32'h0000_0302);
    chk("reset_ftw_ch0", ftw_ch0, 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    rst_ni = 1'b1;
    settle();

    // CSR write in 1-bit MSB-first; new 4-bit mode takes effect without io_update
    cs_low();
    write_reg(7'h00, 32'hF6);
    cs_high();
    settle();
    chk("csr_f6", 32'(csr), 32'h0000_00F6);
    chk("csr_f6_strobes", strobe_cnt, 1);
    chk("csr_f6_addr", 32'(wr_addr), 32'h0);

    // 4-bit mode, channel 0 only: FTW held in shadow until io_update
    cs_low();
    write_reg(7'h00, 32'h46);
    write_reg(7'h04, 32'h1234_5678);
    cs_high();
    settle();
    chk("ftw_pre_update", ftw_ch0, 32'h0);
    io_update_pulse();
    settle();
    chk("ftw_ch0_post", ftw_ch0, 32'h1234_5678);
    chk("ftw_ch1_post", ftw_ch1, 32'h0);

    // Both channels: ACR
    cs_low();
    write_reg(7'h00, 32'hC6);
    write_reg(7'h06, 32'h0013FF);
    cs_high();
    io_update_pulse();
    settle();
    chk("asf_ch0", 32'(asf_ch0), 32'h13FF);
    chk("asf_ch1", 32'(asf_ch1), 32'h13FF);

    // LSB-first 1-bit FR1
    cs_low();
    write_reg(7'h00, 32'hF1);
    write_reg(7'h01, 32'h900000);
    cs_high();
    io_update_pulse();
    settle();
    chk("fr1_lsb_first", 32'(fr1), 32'h0090_0000);

    // Truncated FTW: 12 of 32 bits
    cs_low();
    send_bits(32'h04, 8);
    send_bits(32'hABCDE, 12);
    cs_high();
    m_err = 1'b1;
    io_update_pulse();
    settle();
    chk("trunc_err", 32'(frame_err), 32'h1);
    chk("trunc_ftw_kept", ftw_ch0, 32'h1234_5678);
    cs_low();
    write_reg(7'h03, 32'h00ABCD);
    cs_high();
    io_update_pulse();
    settle();

    // master_reset in the middle of a frame
    cs_low();
    send_bits(32'h04, 8);
    send_bits(32'h5A, 8);
    master_reset_pulse();
    cs_high();
    settle();
    chk("mr_csr", 32'(csr), 32'h0000_00F0);
    chk("mr_cfr_ch0", 32'(cfr_ch0), 32'h0000_0302);
    chk("mr_frame_err", 32'(frame_err), 32'h0);

    // Unsupported address goes to IGNORE
    cs_low();
    send_bits(32'h0A, 8);
    send_bits(32'hFFFF_FFFF, 16);
    cs_high();
    m_err = 1'b1;
    settle();
    chk("bad_addr_err", 32'(frame_err), 32'h1);
    chk("bad_addr_no_strobe", strobe_cnt, m_wr_cnt);

    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 99);
      if (n < 55) begin
        cs_low();
        for (int k = 0; k < $urandom_range(1, 3); k++) rand_write();
        cs_high();
        if ($urandom_range(0, 1) == 1) io_update_pulse();
      end else if (n < 70) begin
        io_update_pulse();
      end else if (n < 82) begin
        bad_frame();
      end else if (n < 90) begin
        for (int k = 0; k < 6; k++) edge_out(4'($urandom()));
      end else begin
        cs_low();
        send_bits($urandom(), 8);
        master_reset_pulse();
        cs_high();
      end
      settle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ad9958_spi_responder.md
Name: ad9958_spi_responder

Overview:
- Synthesizable model of the AD9958 serial port slave: the device end of the link the core drives through the SPI master.
- Decodes instruction and data frames from SCLK/CS_N/SDIO and maintains per-channel shadow registers.
- Copies shadow registers to active outputs on IO_UPDATE.
- Used as an in-FPGA loopback target and as the scoreboard reference in core/SPI integration benches.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for sclk, cs_n, sdio, io_update, master_reset (must be >= 2)
- CSR_DEFAULT, 8'hF0, CSR value after reset or master_reset
- CFR_DEFAULT, 24'h000302, per-channel CFR value after reset or master_reset

Ports:
- clock  in  1  system clock; must be >= 4x the sclk frequency
- reset_n  in  1  asynchronous, active-low reset
- sclk  in  1  serial clock, asynchronous to clock
- cs_n  in  1  chip select, active low
- sdio  in  4  serial data; sdio[0] carries 1-bit modes
- io_update  in  1  commit strobe, asynchronous
- master_reset  in  1  active-high device reset, asynchronous
- csr  out  8  current CSR
- fr1  out  24  active FR1
- cfr_ch0, cfr_ch1  out  24  active CFR per channel
- ftw_ch0, ftw_ch1  out  32  active CFTW0 per channel
- asf_ch0, asf_ch1  out  13  active ACR[12:0] per channel (bit 12 = ASF enable)
- wr_strobe  out  1  one-cycle pulse when a register write completes into shadow
- wr_addr  out  5  address of the last completed write
- frame_err  out  1  sticky flag, cleared only by reset_n or master_reset

Behaviour:
- Reset (reset_n low, async): all outputs and shadows take their defaults: csr=CSR_DEFAULT, cfr=CFR_DEFAULT, all others 0; wr_strobe=0; frame_err=0; FSM=IDLE.
- All async inputs pass through SYNC_STAGES flops.
- sdio uses the same depth as sclk, so data is sampled on the synchronized sclk rising edge with zero skew between them.
- master_reset high (synchronized) has the same effect as reset_n, but synchronously, and holds while high.
- Bits per sclk edge (from csr[2:1]): 00/01 -> 1 bit (sdio[0]); 10 -> 2 bits (sdio[1:0], sdio[1] first-in); 11 -> 4 bits (sdio[3:0], sdio[3] most significant).
- Bit order: csr[0]=0 is MSB-first. csr[0]=1 is LSB-first, in which case the collected N-bit field is bit-reversed at completion. This applies to instruction and data alike.
- FSM states:
  - IDLE: cs_n high. Go to INST on cs_n falling.
  - INST: collect 8 bits.
    - bit7=1 (read): set frame_err, go to IGNORE.
    - Address in {0x00 CSR 8b, 0x01 FR1 24b, 0x03 CFR 24b, 0x04 CFTW0 32b, 0x06 ACR 24b}: load length, go to DATA.
    - Any other address: set frame_err, go to IGNORE.
  - DATA: collect length bits, then:
    - Write to shadow.
    - Pulse wr_strobe on the following cycle, with wr_addr = address.
    - Return to INST (multiple instructions per cs_n frame are allowed).
  - IGNORE: discard bits until cs_n rises.
- cs_n rising in any state: go to IDLE and discard the partial word.
  - If the bit count was nonzero, set frame_err.
  - No shadow register changes.
- Channel registers (CFR, CFTW0, ACR) are written to the shadow of every channel enabled in csr[7:6], bit6=ch0 and bit7=ch1. With csr[7:6]=00 the write is dropped; wr_strobe still pulses.
- CSR takes effect on the cycle after its data completes, without io_update. The new mode and bit order govern the very next instruction.
- FR1/CFR/FTW/ACR are visible on outputs only after an io_update rising edge (synchronized), one cycle after edge detection.
  - Commit copies all shadows to active simultaneously.
  - If a write completes on the same cycle as the commit, the new value is included.
- Mode/width mismatch: the data length must be a multiple of bits-per-edge. All supported lengths are multiples of 4, so no fractional edge can occur.
- sclk edges while cs_n is high are ignored.

Test Plan:
- 1-bit MSB-first: CSR write 0x00,0xF6 -> csr=8'hF6 with no io_update; wr_strobe once, wr_addr=0; subsequent edges take 4 bits.
- 4-bit mode, csr=8'h46 (ch0 only): CFTW0 write 0x04,0x12345678 -> ftw_ch0 stays 0 until io_update pulse, then 32'h12345678; ftw_ch1 stays 0.
- Both channels enabled: ACR write 0x06, 24'h0013FF, then io_update -> asf_ch0=asf_ch1=13'h13FF.
- LSB-first (csr=8'hF1): FR1 bits sent LSB-first for value 24'h900000 -> after io_update fr1=24'h900000.
- cs_n raised after 12 of 32 FTW bits -> frame_err=1, shadows unchanged, next frame decodes normally; address 0x0A -> frame_err=1, IGNORE until cs_n rises.
- master_reset pulse mid-frame -> all outputs return to defaults (csr=F0, cfr_ch*=000302), FSM=IDLE, frame_err=0.
